// File: rtl/board_cell_scan_mux_pkg.sv
// Shared constants and FSM state type for the board-cell scan mux.
// Defaults describe the 3x3 game board: nine 16-bit cells.
package board_cell_scan_mux_pkg;

    localparam int N_CELLS = 9;
    localparam int CELL_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN
    } state_t;

endpackage

// File: rtl/board_cell_scan_mux_if.sv
// Request/response bundle between the board register file and its consumers.
// master drives requests and the consumer ready; slave is the selector.
interface board_cell_scan_mux_if
    import board_cell_scan_mux_pkg::*;
#(
    parameter int N_CH = N_CELLS,
    parameter int W    = CELL_W
);
    localparam int SEL_W = $clog2(N_CH);

    logic [N_CH*W-1:0] in_bus;
    logic              mode;
    logic [SEL_W-1:0]  sel;
    logic              sel_valid;
    logic              sel_ready;
    logic [W-1:0]      out_data;
    logic [SEL_W-1:0]  out_idx;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic              sel_err;

    modport master (
        output in_bus, mode, sel, sel_valid, out_ready,
        input  sel_ready, out_data, out_idx, out_last,
        input  out_valid, sel_err
    );

    modport slave (
        input  in_bus, mode, sel, sel_valid, out_ready,
        output sel_ready, out_data, out_idx, out_last,
        output out_valid, sel_err
    );

endinterface

// File: rtl/board_cell_scan_mux_sel.sv
// Combinational cell picker: one word out of the packed board bus,
// plus a range flag so out-of-board indices never alias a real cell.
module cell_slice_sel
    import board_cell_scan_mux_pkg::*;
#(
    parameter int N_CH  = N_CELLS,
    parameter int W     = CELL_W,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH*W-1:0] in_bus,
    input  logic [SEL_W-1:0]  idx,
    output logic [W-1:0]      word,
    output logic              in_range
);

    always_comb begin
        word = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (idx == SEL_W'(k)) begin
                word = in_bus[k*W +: W];
            end
        end
    end

    // Widened compare so e.g. 9 with N_CH=9 is never truncated into range.
    assign in_range = int'({1'b0, idx}) < N_CH;

endmodule

// File: rtl/board_cell_scan_mux.sv
// Registered N-channel board-cell selector: direct request/response
// lookups or a continuous 0..N_CH-1 scan with a frame-last flag.
module board_cell_scan_mux
    import board_cell_scan_mux_pkg::*;
#(
    parameter int N_CH = N_CELLS,
    parameter int W    = CELL_W
) (
    input logic                   clk,
    input logic                   rst,
    board_cell_scan_mux_if.slave  bus
);

    localparam int SEL_W = $clog2(N_CH);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);

    state_t           state;
    logic [SEL_W-1:0] ctr;
    logic [W-1:0]     data_q;
    logic [SEL_W-1:0] idx_q;
    logic             last_q;
    logic             valid_q;
    logic             err_q;

    logic             free;
    logic             accept;
    logic [SEL_W-1:0] idx;
    logic [W-1:0]     word;
    logic             in_range;

    // Output slot can take a new beat when empty or being drained now.
    assign free   = !valid_q || bus.out_ready;
    assign accept = bus.sel_valid && bus.sel_ready;
    assign idx    = (state == SCAN) ? ctr : bus.sel;

    assign bus.sel_ready = (state == DIRECT) && free && !bus.mode;

    cell_slice_sel #(
        .N_CH  (N_CH),
        .W     (W),
        .SEL_W (SEL_W)
    ) u_sel (
        .in_bus   (bus.in_bus),
        .idx      (idx),
        .word     (word),
        .in_range (in_range)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ctr     <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    ctr   <= '0;
                    state <= bus.mode ? SCAN : DIRECT;
                end
                DIRECT: begin
                    if (free && bus.mode) begin
                        state   <= SCAN;
                        ctr     <= '0;
                        valid_q <= 1'b0;
                    end else if (accept && in_range) begin
                        data_q  <= word;
                        idx_q   <= bus.sel;
                        last_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end else if (accept) begin
                        err_q   <= 1'b1;
                        valid_q <= 1'b0;
                    end else if (valid_q && bus.out_ready) begin
                        valid_q <= 1'b0;
                    end
                end
                SCAN: begin
                    if (free && !bus.mode) begin
                        state   <= DIRECT;
                        valid_q <= 1'b0;
                    end else if (free) begin
                        data_q  <= word;
                        idx_q   <= ctr;
                        last_q  <= (ctr == LAST);
                        valid_q <= 1'b1;
                        ctr     <= (ctr == LAST) ? '0 : ctr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = last_q;
    assign bus.out_valid = valid_q;
    assign bus.sel_err   = err_q;

endmodule

// File: tb/tb_board_cell_scan_mux.sv
// Directed bench for board_cell_scan_mux: 9x16 board plus a 4x8 instance.
// Inputs change on the falling edge, outputs are checked there too.
module tb_board_cell_scan_mux;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    board_cell_scan_mux_if #(.N_CH(9), .W(16)) bi ();
    board_cell_scan_mux_if #(.N_CH(4), .W(8))  si ();

    board_cell_scan_mux #(.N_CH(9), .W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bi.slave)
    );

    board_cell_scan_mux #(.N_CH(4), .W(8)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (si.slave)
    );

    task automatic test_reset();
        rst = 1'b1;
        bi.mode = 1'b0; bi.sel = '0; bi.sel_valid = 1'b0;
        bi.out_ready = 1'b0; bi.in_bus = '0;
        si.mode = 1'b0; si.sel = '0; si.sel_valid = 1'b0;
        si.out_ready = 1'b0; si.in_bus = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bi.out_valid, bi.out_data, bi.out_idx, bi.out_last,
             bi.sel_err, bi.sel_ready} !== '0) begin
            failures++;
            $display("FAIL reset_big got v=%b d=%h i=%0d l=%b e=%b r=%b req all 0",
                     bi.out_valid, bi.out_data, bi.out_idx, bi.out_last,
                     bi.sel_err, bi.sel_ready);
        end
        checks++;
        if ({si.out_valid, si.out_data, si.out_idx, si.out_last,
             si.sel_err, si.sel_ready} !== '0) begin
            failures++;
            $display("FAIL reset_small got v=%b d=%h i=%0d req all 0",
                     si.out_valid, si.out_data, si.out_idx);
        end
        rst = 1'b0;
    endtask

    task automatic test_direct();
        bit seen = 1'b0;
        bi.in_bus[4*16 +: 16] = 16'h00A5;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bi.sel_ready;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL direct_ready got sel_ready=0 req 1 within 10 cycles");
        end
        bi.sel = 4'd4;
        bi.sel_valid = 1'b1;
        @(negedge clk);
        bi.sel_valid = 1'b0;
        checks++;
        if (bi.out_data !== 16'h00A5 || bi.out_idx !== 4'd4 ||
            bi.out_valid !== 1'b1 || bi.sel_err !== 1'b0 ||
            bi.out_last !== 1'b0) begin
            failures++;
            $display("FAIL direct_resp got d=%h i=%0d v=%b e=%b l=%b req d=00a5 i=4 v=1 e=0 l=0",
                     bi.out_data, bi.out_idx, bi.out_valid, bi.sel_err, bi.out_last);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 3; i++) begin
            bi.in_bus = ~bi.in_bus;
            #1;
            checks++;
            if (bi.sel_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_ready[%0d] got %b req 0", i, bi.sel_ready);
            end
            @(negedge clk);
            checks++;
            if (bi.out_data !== 16'h00A5 || bi.out_valid !== 1'b1) begin
                failures++;
                $display("FAIL hold_data[%0d] got d=%h v=%b req d=00a5 v=1",
                         i, bi.out_data, bi.out_valid);
            end
        end
        bi.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bi.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_consume got v=%b req 0", bi.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] s [4];
        s = '{4'd2, 4'd7, 4'd0, 4'd8};
        for (int k = 0; k < 9; k++) bi.in_bus[k*16 +: 16] = 16'h1000 + 16'(k);
        bi.sel = s[0];
        bi.sel_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            if (bi.out_valid !== 1'b1 || bi.out_idx !== s[i-1] ||
                bi.out_data !== 16'h1000 + 16'(s[i-1])) begin
                failures++;
                $display("FAIL b2b[%0d] got v=%b i=%0d d=%h req v=1 i=%0d d=%h",
                         i - 1, bi.out_valid, bi.out_idx, bi.out_data,
                         s[i-1], 16'h1000 + 16'(s[i-1]));
            end
            if (i < 4) bi.sel = s[i];
            else bi.sel_valid = 1'b0;
        end
    endtask

    task automatic test_sel_err();
        @(negedge clk);
        checks++;
        if (bi.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL err_pre got v=%b req 0", bi.out_valid);
        end
        bi.sel = 4'd9;
        bi.sel_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (bi.sel_err !== 1'b1 || bi.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL err_pulse got e=%b v=%b req e=1 v=0",
                     bi.sel_err, bi.out_valid);
        end
        bi.sel = 4'd8;
        @(negedge clk);
        bi.sel_valid = 1'b0;
        checks++;
        if (bi.sel_err !== 1'b0 || bi.out_valid !== 1'b1 ||
            bi.out_idx !== 4'd8 || bi.out_data !== 16'h1008 ||
            bi.out_last !== 1'b0) begin
            failures++;
            $display("FAIL err_next got e=%b v=%b i=%0d d=%h l=%b req e=0 v=1 i=8 d=1008 l=0",
                     bi.sel_err, bi.out_valid, bi.out_idx, bi.out_data, bi.out_last);
        end
    endtask

    task automatic test_scan();
        bit seen = 1'b0;
        for (int k = 0; k < 9; k++) bi.in_bus[k*16 +: 16] = 16'(k * 16'h0101);
        bi.mode = 1'b1;
        bi.out_ready = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bi.out_valid;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL scan_start got out_valid=0 req 1 within 10 cycles");
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (bi.out_valid !== 1'b1 || bi.out_idx !== 4'(i % 9) ||
                bi.out_data !== 16'((i % 9) * 16'h0101) ||
                bi.out_last !== ((i % 9) == 8)) begin
                failures++;
                $display("FAIL scan_seq[%0d] got v=%b i=%0d d=%h l=%b req v=1 i=%0d d=%h l=%b",
                         i, bi.out_valid, bi.out_idx, bi.out_data, bi.out_last,
                         i % 9, 16'((i % 9) * 16'h0101), (i % 9) == 8);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_scan_hold();
        bit seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            if (bi.out_valid && bi.out_idx == 4'd3) seen = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL scanhold_find got no idx 3 req idx 3 within 12 cycles");
        end
        bi.out_ready = 1'b0;
        bi.mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bi.out_valid !== 1'b1 || bi.out_idx !== 4'd3 ||
                bi.out_data !== 16'h0303 || bi.sel_ready !== 1'b0) begin
                failures++;
                $display("FAIL scanhold[%0d] got v=%b i=%0d d=%h r=%b req v=1 i=3 d=0303 r=0",
                         i, bi.out_valid, bi.out_idx, bi.out_data, bi.sel_ready);
            end
        end
        bi.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bi.out_valid !== 1'b0 || bi.sel_ready !== 1'b1) begin
            failures++;
            $display("FAIL scanhold_exit got v=%b r=%b req v=0 r=1",
                     bi.out_valid, bi.sel_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bi.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL scanhold_quiet[%0d] got v=%b req 0", i, bi.out_valid);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        bit seen = 1'b0;
        bi.mode = 1'b1;
        bi.out_ready = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bi.out_valid && bi.out_idx == 4'd5;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL midrst_find got no idx 5 req idx 5 within 20 cycles");
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bi.out_valid, bi.out_data, bi.out_idx, bi.out_last,
             bi.sel_err, bi.sel_ready} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs got v=%b d=%h i=%0d l=%b req all 0",
                     bi.out_valid, bi.out_data, bi.out_idx, bi.out_last);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bi.out_valid;
        end
        checks++;
        if (!seen || bi.out_idx !== 4'd0 || bi.out_data !== 16'h0000) begin
            failures++;
            $display("FAIL midrst_restart got v=%b i=%0d d=%h req v=1 i=0 d=0000",
                     bi.out_valid, bi.out_idx, bi.out_data);
        end
    endtask

    task automatic test_small_direct();
        bit seen = 1'b0;
        si.in_bus[2*8 +: 8] = 8'h5A;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = si.sel_ready;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL small_ready got sel_ready=0 req 1 within 10 cycles");
        end
        si.sel = 2'd2;
        si.sel_valid = 1'b1;
        @(negedge clk);
        si.sel_valid = 1'b0;
        checks++;
        if (si.out_data !== 8'h5A || si.out_idx !== 2'd2 ||
            si.out_valid !== 1'b1 || si.sel_err !== 1'b0 ||
            si.out_last !== 1'b0) begin
            failures++;
            $display("FAIL small_direct got d=%h i=%0d v=%b e=%b req d=5a i=2 v=1 e=0",
                     si.out_data, si.out_idx, si.out_valid, si.sel_err);
        end
    endtask

    task automatic test_small_scan();
        bit seen = 1'b0;
        for (int k = 0; k < 4; k++) si.in_bus[k*8 +: 8] = 8'(k * 8'h11);
        si.mode = 1'b1;
        si.out_ready = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = si.out_valid;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL small_scan_start got out_valid=0 req 1 within 10 cycles");
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (si.out_valid !== 1'b1 || si.out_idx !== 2'(i % 4) ||
                si.out_data !== 8'((i % 4) * 8'h11) ||
                si.out_last !== ((i % 4) == 3)) begin
                failures++;
                $display("FAIL small_scan[%0d] got v=%b i=%0d d=%h l=%b req i=%0d d=%h l=%b",
                         i, si.out_valid, si.out_idx, si.out_data, si.out_last,
                         i % 4, 8'((i % 4) * 8'h11), (i % 4) == 3);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_hold();
        test_back_to_back();
        test_sel_err();
        test_scan();
        test_scan_hold();
        test_reset_mid_scan();
        test_small_direct();
        test_small_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
